// File: rtl/sevenseg_scan_driver_if.sv
// Signal bundle between display-producing logic and the seven-segment scan driver.
// The master supplies digit data and display controls; the slave drives the panel pins.
interface sevenseg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] Digits;
  logic                    Load;
  logic [NUM_DIGITS-1:0]   DigitEn;
  logic [NUM_DIGITS-1:0]   Blink;
  logic                    LzSup;
  logic [6:0]              Segout;
  logic [NUM_DIGITS-1:0]   Anode;

  modport master (
    output Digits, Load, DigitEn, Blink, LzSup,
    input  Segout, Anode
  );

  modport slave (
    input  Digits, Load, DigitEn, Blink, LzSup,
    output Segout, Anode
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadowed hex digits, guard-timed
// scanning, per-digit blank/blink and leading-zero suppression.
module sevenseg_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned BLINK_SCANS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  sevenseg_scan_driver_if.slave bus
);
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(BLINK_SCANS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic                    phase_q, phase_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    run;
  logic                    in_guard;
  logic                    blank;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    scan_d   = scan_q;
    phase_d  = phase_q;
    shadow_d = bus.Load ? bus.Digits : shadow_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (scan_q == SCAN_LAST) begin
          scan_d  = '0;
          phase_d = ~phase_q;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // zero_from[j] is set when nibble j and every more-significant nibble are zero.
  always_comb begin
    run       = 1'b1;
    zero_from = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      run = run & (shadow_q[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      zero_from[NUM_DIGITS-1-i] = run;
    end
  end

  always_comb begin
    nib      = shadow_q[{idx_q, 2'b00} +: 4];
    in_guard = (32'(presc_q) < GUARD);
    blank    = !bus.DigitEn[idx_q]
             || (bus.Blink[idx_q] && phase_q)
             || (bus.LzSup && (idx_q != '0) && zero_from[idx_q]);
    seg_d    = (in_guard || blank) ? '1 : glyph(nib);
    an_d     = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = in_guard || (idx_q != IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      scan_q   <= '0;
      phase_q  <= 1'b0;
      seg_q    <= '1;
      an_q     <= '1;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      scan_q   <= scan_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bus.Segout = seg_q;
  assign bus.Anode  = an_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: directed scenarios plus random stimulus, checked against
// a cycle-count based reference of the display behaviour.
module tb_sevenseg_scan_driver;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GD = 1;
  localparam int BS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  logic [15:0] shadow_m = '0;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic [6:0]  GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  sevenseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .GUARD(GD),
    .BLINK_SCANS(BS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Expected display for the c-th edge after reset release, from slot arithmetic.
  function automatic void model_out(input int c, input logic [15:0] sh, input logic [3:0] en,
                                    input logic [3:0] bl, input logic lz,
                                    output logic [6:0] s, output logic [3:0] a);
    int slot, idx, ph;
    slot = c % RD;
    idx  = (c / RD) % ND;
    ph   = (c / (RD * ND * BS)) % 2;
    s = 7'h7F;
    a = 4'hF;
    if (slot >= GD) begin
      a = ~(4'b0001 << idx);
      if (en[idx] && !(bl[idx] && ph == 1) && !(lz && idx != 0 && (sh >> (4 * idx)) == 16'h0))
        s = GLYPH[sh[4*idx +: 4]];
    end
  endfunction

  task automatic tick();
    logic [6:0] s;
    logic [3:0] a;
    if (reset) begin
      s = 7'h7F;
      a = 4'hF;
    end else begin
      model_out(cyc, shadow_m, bus.DigitEn, bus.Blink, bus.LzSup, s, a);
    end
    @(posedge clk);
    if (reset) begin
      cyc = 0;
      shadow_m = '0;
    end else begin
      cyc++;
      if (bus.Load) shadow_m = bus.Digits;
    end
    exp_seg = s;
    exp_an  = a;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.Load = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    bus.Digits = v;
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
  endtask

  task automatic test_reset();
    bus.Digits = 16'hFFFF; bus.DigitEn = 4'hF; bus.Blink = 4'h0; bus.LzSup = 1'b0;
    bus.Load = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.Segout !== 7'h7F || bus.Anode !== 4'hF) begin
      errors++;
      $display("FAIL reset_state seg=%b an=%b want seg=1111111 an=1111", bus.Segout, bus.Anode);
    end
    bus.Load = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.Segout !== 7'h7F || bus.Anode !== 4'hF) begin
      errors++;
      $display("FAIL reset_guard seg=%b an=%b want seg=1111111 an=1111", bus.Segout, bus.Anode);
    end
    tick();
    checks++;
    if (bus.Segout !== 7'b1000000 || bus.Anode !== 4'b1110) begin
      errors++;
      $display("FAIL reset_shadow_zero seg=%b an=%b want seg=1000000 an=1110", bus.Segout, bus.Anode);
    end
  endtask

  task automatic test_scan();
    do_reset();
    bus.DigitEn = 4'hF; bus.Blink = 4'h0; bus.LzSup = 1'b0;
    load(16'h12AF);
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL scan c=%0d seg=%b an=%b want seg=%b an=%b", cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
      if (cyc - 1 == 13) begin
        checks++;
        if (bus.Segout !== 7'b1111001 || bus.Anode !== 4'b0111) begin
          errors++;
          $display("FAIL scan_digit3 seg=%b an=%b want seg=1111001 an=0111", bus.Segout, bus.Anode);
        end
      end
    end
  endtask

  task automatic test_lzsup();
    do_reset();
    bus.DigitEn = 4'hF; bus.Blink = 4'h0; bus.LzSup = 1'b1;
    load(16'h0050);
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL lzsup c=%0d seg=%b an=%b want seg=%b an=%b", cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
      if (cyc - 1 == 9) begin
        checks++;
        if (bus.Segout !== 7'h7F || bus.Anode !== 4'b1011) begin
          errors++;
          $display("FAIL lzsup_digit2 seg=%b an=%b want seg=1111111 an=1011", bus.Segout, bus.Anode);
        end
      end
    end
    load(16'h0000);
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL lzsup_zero c=%0d seg=%b an=%b want seg=%b an=%b", cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_blink();
    do_reset();
    bus.DigitEn = 4'hF; bus.Blink = 4'b0010; bus.LzSup = 1'b0;
    load(16'h12AF);
    for (int k = 0; k < 100; k++) begin
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL blink c=%0d seg=%b an=%b want seg=%b an=%b", cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
      if (cyc - 1 == 37) begin
        checks++;
        if (bus.Segout !== 7'h7F || bus.Anode !== 4'b1101) begin
          errors++;
          $display("FAIL blink_off seg=%b an=%b want seg=1111111 an=1101", bus.Segout, bus.Anode);
        end
      end
      if (cyc - 1 == 69) begin
        checks++;
        if (bus.Segout !== 7'b0001000 || bus.Anode !== 4'b1101) begin
          errors++;
          $display("FAIL blink_on seg=%b an=%b want seg=0001000 an=1101", bus.Segout, bus.Anode);
        end
      end
    end
  endtask

  task automatic test_midload();
    do_reset();
    bus.DigitEn = 4'hF; bus.Blink = 4'h0; bus.LzSup = 1'b0;
    load(16'h12AF);
    for (int k = 0; k < 9; k++) tick();
    load(16'h1BAF);
    checks++;
    if (bus.Segout !== 7'b0100100 || bus.Anode !== 4'b1011) begin
      errors++;
      $display("FAIL midload_before seg=%b an=%b want seg=0100100 an=1011", bus.Segout, bus.Anode);
    end
    for (int k = 0; k < 24; k++) begin
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL midload c=%0d seg=%b an=%b want seg=%b an=%b", cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
      if (k == 0) begin
        checks++;
        if (bus.Segout !== 7'b0000011) begin
          errors++;
          $display("FAIL midload_after seg=%b want 0000011", bus.Segout);
        end
      end
    end
  endtask

  task automatic test_digiten_reset();
    do_reset();
    bus.DigitEn = 4'b0111; bus.Blink = 4'h0; bus.LzSup = 1'b0;
    load(16'h12AF);
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL digiten c=%0d seg=%b an=%b want seg=%b an=%b", cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.Segout !== 7'h7F || bus.Anode !== 4'hF) begin
      errors++;
      $display("FAIL midscan_reset seg=%b an=%b want seg=1111111 an=1111", bus.Segout, bus.Anode);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.Segout !== 7'b1000000 || bus.Anode !== 4'b1110) begin
      errors++;
      $display("FAIL post_reset_digit0 seg=%b an=%b want seg=1000000 an=1110", bus.Segout, bus.Anode);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL digiten_post c=%0d seg=%b an=%b want seg=%b an=%b", cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_glyph_sweep();
    do_reset();
    bus.DigitEn = 4'hF; bus.Blink = 4'h0; bus.LzSup = 1'b0;
    for (int v = 0; v < 16; v++) begin
      load({4{4'(v)}});
      for (int k = 0; k < 16; k++) begin
        tick();
        checks++;
        if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
          errors++;
          $display("FAIL glyph v=%h c=%0d seg=%b an=%b want seg=%b an=%b", v, cyc-1, bus.Segout, bus.Anode, exp_seg, exp_an);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      bus.Digits  = 16'($urandom);
      bus.Load    = ($urandom_range(0, 3) == 0);
      bus.DigitEn = 4'($urandom);
      bus.Blink   = 4'($urandom);
      bus.LzSup   = 1'($urandom);
      reset       = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (bus.Segout !== exp_seg || bus.Anode !== exp_an) begin
        errors++;
        $display("FAIL random k=%0d seg=%b an=%b want seg=%b an=%b", k, bus.Segout, bus.Anode, exp_seg, exp_an);
      end
    end
    reset = 1'b0;
    bus.Load = 1'b0;
  endtask

  initial begin
    bus.Digits = '0; bus.Load = 1'b0; bus.DigitEn = '0; bus.Blink = '0; bus.LzSup = 1'b0;
    test_reset();
    test_scan();
    test_lzsup();
    test_blink();
    test_midload();
    test_digiten_reset();
    test_glyph_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits, generalising the single-digit hex decoder to NUM_DIGITS digits behind one shared segment bus. Latches a packed word of hex nibbles on a load strobe, scans the digits at a programmable refresh rate with anti-ghosting guard time, and adds per-digit blanking, per-digit blinking and leading-zero suppression. Sits between the game score/timer logic and the board display pins.

## Interface

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal 1..8
- REFRESH_DIV, 50000, clock cycles each digit is selected; legal ≥ 2
- GUARD, 2, cycles at the start of each digit slot with all anodes off; legal 0..REFRESH_DIV-1
- BLINK_SCANS, 64, complete scans per blink half-period; legal ≥ 1

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- Digits  in  4*NUM_DIGITS  hex values; nibble i (bits 4i+3:4i) is digit i, digit 0 least significant
- Load  in  1  when high at a clock edge, Digits is captured into the shadow register
- DigitEn  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
- Blink  in  NUM_DIGITS  per-digit blink enable
- LzSup  in  1  leading-zero suppression enable
- Segout  out  7  active-low segments, bit order g f e d c b a (bit 6 = g)
- Anode  out  NUM_DIGITS  active-low one-hot digit select

## Operation

- Shadow register: NUM_DIGITS nibbles, loaded from Digits on an edge with Load=1, otherwise held. DigitEn, Blink and LzSup are used live, not shadowed.
- Prescaler: counts 0..REFRESH_DIV-1, wraps to 0. At terminal count the digit index advances: index NUM_DIGITS-1 wraps to 0. With NUM_DIGITS=1, index stays 0.
- Scan counter: increments when the index wraps; at BLINK_SCANS-1 it returns to 0 and the blink phase toggles.
- Glyphs, active-low, 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110. Blank = 1111111.
- A digit is blanked (Segout=1111111, anode still selected) if any of the following holds:
  - its DigitEn bit is 0;
  - its Blink bit is 1 and the blink phase is 1;
  - LzSup is 1, index ≠ 0, and the nibble at that index and every more-significant nibble in the shadow are all zero.
- Digit 0 is never zero-suppressed, so a shadow of all zeros shows a single "0".
- Guard: while the prescaler value is < GUARD, Anode is all ones and Segout is 1111111.
- Otherwise Anode has only bit [index] low.

## Timing

- Segout and Anode are registered. The values driven after edge t are computed from the shadow, index, prescaler, phase and live inputs as sampled before edge t.
- Load latency: Load=1 at edge t updates the shadow at t. The new glyph appears on Segout at edge t+1 if that digit is selected and not in guard.
- Live-input latency: DigitEn, Blink and LzSup affect Segout one edge after they are sampled.
- Slot length: each digit is selected for exactly REFRESH_DIV cycles, of which the first GUARD show all anodes off. A full scan takes NUM_DIGITS*REFRESH_DIV cycles.
- Blink half-period: BLINK_SCANS*NUM_DIGITS*REFRESH_DIV cycles.
- Reset values, applied at any edge with reset=1 and effective mid-scan:
  - prescaler = 0, index = 0, scan counter = 0, blink phase = 0 (visible);
  - shadow = all zeros;
  - Segout = 1111111, Anode = all ones.
- Reset has priority over Load.
- Following the first edge after reset deasserts, the block starts in digit 0's guard window, or displays digit 0 directly if GUARD=0.
- Load coincident with an index advance: the shadow update and the index change both take effect at the same edge, with no special ordering.

## Test plan

All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, BLINK_SCANS=2.

- Reset, then Load Digits=16'h12AF, DigitEn=4'hF, all else 0:
  - each 4-cycle slot shows Anode=1111 for 1 cycle, then 3 cycles of the selected digit;
  - digit 0: Anode 1110, Segout 0001110;
  - digit 1: Anode 1101, Segout 0001000;
  - digit 2: Anode 1011, Segout 0100100;
  - digit 3: Anode 0111, Segout 1111001;
  - then wrap to digit 0.
- Load 16'h0050 with LzSup=1:
  - digits 3 and 2 blank (Segout=1111111, anode still selected);
  - digit 1 shows 0010010, digit 0 shows 1000000.
  - Load 16'h0000: only digit 0 shows 1000000.
- Blink=4'b0010 with 16'h12AF loaded:
  - digit 1 shows 0001000 for the first 32 cycles;
  - blank for the next 32;
  - visible again after that;
  - all other digits unaffected.
- Load pulse mid-slot of digit 2, changing 16'h12AF to 16'h1BAF:
  - Segout changes from 0100100 to 0000011 exactly one edge after the Load edge;
  - slot length is unchanged.
- DigitEn=4'b0111: digit 3 slots show Anode=0111 with Segout=1111111.
  - Reset asserted mid-slot of digit 2: outputs go 1111111/1111 at the next edge;
  - after release, digit 0 with an empty shadow shows 1000000.
- Sweep a single digit through Digits values 0..F: every glyph matches the encoding table.
